// File: rtl/control_sequencer.sv
// ============================================================================
// Module   : control_sequencer
// Purpose  : Fetch/decode/execute controller for the 8-bit processor. It
//            sequences the 16-entry program/data memory, the instruction
//            register, the program counter and the accumulator/ALU/output
//            strobes. It supports free-run and single-step modes and halts
//            on HLT.
// Ports    : clk, rst          - clock (rising edge), async active-high reset
//            run, step         - free-run level / single-step pulse
//            mem_rdata         - memory read data
//            mem_addr, mem_oe_n, mem_we - memory address / OE (low) / write
//            op_code, pc       - IR[7:4] and the program counter
//            acc_load, alu_sub, out_load - datapath control pulses
//            instr_done, halted - instruction completion pulse / sticky halt
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic [7:0] mem_rdata,
    output logic [3:0] mem_addr,
    output logic       mem_oe_n,
    output logic       mem_we,
    output logic [3:0] op_code,
    output logic [3:0] pc,
    output logic       acc_load,
    output logic       alu_sub,
    output logic       out_load,
    output logic       instr_done,
    output logic       halted
);

    localparam logic [3:0] C_OP_LDA = 4'h0;
    localparam logic [3:0] C_OP_ADD = 4'h4;
    localparam logic [3:0] C_OP_SUB = 4'hC;
    localparam logic [3:0] C_OP_STA = 4'h8;
    localparam logic [3:0] C_OP_JMP = 4'h6;
    localparam logic [3:0] C_OP_OUT = 4'hE;
    localparam logic [3:0] C_OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_F0   = 3'd1,
        S_F1   = 3'd2,
        S_DEC  = 3'd3,
        S_E0   = 3'd4,
        S_E1   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_ir;
    logic [3:0] r_pc;
    logic [3:0] w_opcode;
    logic [3:0] w_operand;
    logic       w_is_mem_read;

    assign w_opcode      = r_ir[7:4];
    assign w_operand     = r_ir[3:0];
    assign w_is_mem_read = (w_opcode == C_OP_LDA) || (w_opcode == C_OP_ADD) ||
                           (w_opcode == C_OP_SUB);
    assign op_code       = w_opcode;
    assign pc            = r_pc;

    // State, instruction register and program counter. Because every strobe
    // is decoded from these registers, asserting rst drops the strobes
    // (including a pending write) immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ir    <= 8'h00;
            r_pc    <= 4'h0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_F1) begin
                r_ir <= mem_rdata;
                r_pc <= r_pc + 4'd1;       // natural 4-bit wrap 15 -> 0
            end else if ((r_state == S_E0) && (w_opcode == C_OP_JMP)) begin
                r_pc <= w_operand;
            end
        end
    end

    // Next-state and output decode. Outputs depend only on registered state,
    // IR and pc; run/step influence only the next state.
    always_comb begin
        w_next_state = r_state;
        mem_addr     = r_pc;
        mem_oe_n     = 1'b1;
        mem_we       = 1'b0;
        acc_load     = 1'b0;
        alu_sub      = 1'b0;
        out_load     = 1'b0;
        instr_done   = 1'b0;
        halted       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run || step) begin
                    w_next_state = S_F0;
                end
            end
            S_F0: begin
                mem_oe_n     = 1'b0;
                w_next_state = S_F1;
            end
            S_F1: begin
                mem_oe_n     = 1'b0;
                w_next_state = S_DEC;
            end
            S_DEC: begin
                w_next_state = (w_opcode == C_OP_HLT) ? S_HALT : S_E0;
            end
            S_E0: begin
                if (w_is_mem_read) begin
                    mem_addr = w_operand;
                    mem_oe_n = 1'b0;
                end else if (w_opcode == C_OP_STA) begin
                    mem_addr = w_operand;
                    mem_we   = 1'b1;
                end
                w_next_state = S_E1;
            end
            S_E1: begin
                // Operand stays on the bus so the datapath samples it with
                // acc_load at the end of this cycle.
                if (w_is_mem_read) begin
                    mem_addr = w_operand;
                    mem_oe_n = 1'b0;
                    acc_load = 1'b1;
                    alu_sub  = (w_opcode == C_OP_SUB);
                end else if (w_opcode == C_OP_OUT) begin
                    out_load = 1'b1;
                end
                instr_done   = 1'b1;
                w_next_state = run ? S_F0 : S_IDLE;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module   : tb_control_sequencer
// Purpose  : Directed self-checking bench for control_sequencer with a small
//            memory and accumulator/output datapath model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic       step;
    logic [7:0] mem_rdata;
    logic [3:0] mem_addr;
    logic       mem_oe_n;
    logic       mem_we;
    logic [3:0] op_code;
    logic [3:0] pc;
    logic       acc_load;
    logic       alu_sub;
    logic       out_load;
    logic       instr_done;
    logic       halted;

    int tests;
    int fails;

    logic [7:0] mem [16];
    logic [7:0] acc;
    logic [7:0] out_reg;

    control_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_oe_n   (mem_oe_n),
        .mem_we     (mem_we),
        .op_code    (op_code),
        .pc         (pc),
        .acc_load   (acc_load),
        .alu_sub    (alu_sub),
        .out_load   (out_load),
        .instr_done (instr_done),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Memory write port and accumulator/output datapath
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= 8'h00;
            out_reg <= 8'h00;
        end else begin
            if (acc_load) begin
                if (alu_sub)             acc <= acc - mem_rdata;
                else if (op_code == 4'h0) acc <= mem_rdata;
                else                     acc <= acc + mem_rdata;
            end
            if (out_load) out_reg <= acc;
            if (mem_we)   mem[mem_addr] <= acc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) mem[i] = 8'h30;
    endtask

    task automatic do_reset();
        run  = 1'b0;
        step = 1'b0;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        if ({mem_addr, mem_oe_n, mem_we, op_code, pc, acc_load, alu_sub,
             out_load, instr_done, halted} !== {4'h0, 1'b1, 1'b0, 4'h0, 4'h0,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL %s: addr=%h oe_n=%b we=%b op=%h pc=%h al=%b sub=%b ol=%b done=%b halt=%b, required addr=0 oe_n=1 others 0",
                     tag, mem_addr, mem_oe_n, mem_we, op_code, pc, acc_load,
                     alu_sub, out_load, instr_done, halted);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; step = 1'b0;
        #3;
        check_reset_outputs("reset_async");
        tick();
        check_reset_outputs("reset_clocked");
        rst = 1'b0;
        tick();
        check_reset_outputs("idle_no_start");
    endtask

    task automatic test_free_run();
        fill_nop();
        mem[0] = 8'h08; mem[1] = 8'hC9; mem[2] = 8'hEE; mem[3] = 8'hFF;
        mem[8] = 8'h01; mem[9] = 8'h08;
        do_reset();
        run = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            tests++;
            if ({acc_load, alu_sub, out_load, halted} !==
                {(c == 5 || c == 10), (c == 10), (c == 15), (c >= 19)}) begin
                fails++;
                $display("FAIL free_run_cycle%0d: al/sub/ol/halt=%b%b%b%b, required %b%b%b%b",
                         c, acc_load, alu_sub, out_load, halted,
                         (c == 5 || c == 10), (c == 10), (c == 15), (c >= 19));
            end
        end
        tests++;
        if (out_reg !== 8'hF9) begin
            fails++;
            $display("FAIL free_run_output: got %h, required f9", out_reg);
        end
        run = 1'b0;
        tick();
        tests++;
        if (halted !== 1'b1) begin
            fails++;
            $display("FAIL halt_sticky: got %b, required 1", halted);
        end
    endtask

    task automatic test_single_step();
        int dones;
        fill_nop();
        mem[0] = 8'h20;
        do_reset();
        dones = 0;
        step = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            step = (c >= 1 && c <= 4);   // extra pulses during the instruction
            if (instr_done) dones++;
            if (c >= 6) begin
                tests++;
                if (mem_oe_n !== 1'b1 || instr_done !== 1'b0) begin
                    fails++;
                    $display("FAIL step_idle_cycle%0d: oe_n=%b done=%b, required oe_n=1 done=0",
                             c, mem_oe_n, instr_done);
                end
            end
            if (c == 5) begin
                tests++;
                if (instr_done !== 1'b1) begin
                    fails++;
                    $display("FAIL step_done_cycle5: got %b, required 1", instr_done);
                end
            end
        end
        tests++;
        if (dones !== 1 || pc !== 4'h1) begin
            fails++;
            $display("FAIL step_summary: dones=%0d pc=%h, required dones=1 pc=1", dones, pc);
        end
    endtask

    task automatic test_sta();
        int we_cycles;
        fill_nop();
        mem[0]  = 8'h8A;
        mem[10] = 8'h55;
        do_reset();
        we_cycles = 0;
        step = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            step = 1'b0;
            if (mem_we) we_cycles++;
            tests++;
            if (acc_load !== 1'b0 || (mem_we === 1'b1 && mem_oe_n !== 1'b1)) begin
                fails++;
                $display("FAIL sta_strobes_cycle%0d: acc_load=%b we=%b oe_n=%b, required acc_load=0 oe_n=1 when we",
                         c, acc_load, mem_we, mem_oe_n);
            end
            if (c == 4) begin
                tests++;
                if ({mem_we, mem_addr, mem_oe_n} !== {1'b1, 4'hA, 1'b1}) begin
                    fails++;
                    $display("FAIL sta_e0: we=%b addr=%h oe_n=%b, required we=1 addr=a oe_n=1",
                             mem_we, mem_addr, mem_oe_n);
                end
            end
        end
        tests++;
        if (we_cycles !== 1 || mem[10] !== 8'h00) begin
            fails++;
            $display("FAIL sta_write: we_cycles=%0d mem[a]=%h, required 1 and 00", we_cycles, mem[10]);
        end
    endtask

    task automatic test_jmp_wrap();
        fill_nop();
        mem[0] = 8'h6F;
        mem[15] = 8'h30;
        do_reset();
        run = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            tick();
            if (c == 5) begin
                tests++;
                if (pc !== 4'hF) begin
                    fails++;
                    $display("FAIL jmp_pc: got %h, required f", pc);
                end
            end
            if (c == 6) begin
                tests++;
                if (mem_addr !== 4'hF || mem_oe_n !== 1'b0) begin
                    fails++;
                    $display("FAIL jmp_fetch: addr=%h oe_n=%b, required addr=f oe_n=0", mem_addr, mem_oe_n);
                end
            end
            if (c == 8) begin
                tests++;
                if (pc !== 4'h0) begin
                    fails++;
                    $display("FAIL pc_wrap: got %h, required 0", pc);
                end
            end
            if (c == 11) begin
                tests++;
                if (mem_addr !== 4'h0 || mem_oe_n !== 1'b0) begin
                    fails++;
                    $display("FAIL wrap_fetch: addr=%h oe_n=%b, required addr=0 oe_n=0", mem_addr, mem_oe_n);
                end
            end
        end
        run = 1'b0;
    endtask

    task automatic test_reset_mid_sta();
        fill_nop();
        mem[0]  = 8'h8A;
        mem[10] = 8'h77;
        do_reset();
        step = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            step = 1'b0;
        end
        tests++;
        if (mem_we !== 1'b1) begin
            fails++;
            $display("FAIL rst_sta_pre: we=%b, required 1", mem_we);
        end
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (mem_we !== 1'b0) begin
            fails++;
            $display("FAIL rst_sta_async_we: got %b, required 0", mem_we);
        end
        check_reset_outputs("rst_sta_outputs");
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if (mem[10] !== 8'h77 || pc !== 4'h0) begin
            fails++;
            $display("FAIL rst_sta_aborted: mem[a]=%h pc=%h, required 77 and 0", mem[10], pc);
        end
    endtask

    task automatic test_undefined_opcode();
        fill_nop();
        mem[0] = 8'h23;
        mem[1] = 8'hA5;
        do_reset();
        run = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 6) run = 1'b0;   // second instruction must still finish
            tests++;
            if ({acc_load, mem_we, out_load, instr_done} !==
                {1'b0, 1'b0, 1'b0, (c == 5 || c == 10)}) begin
                fails++;
                $display("FAIL undef_cycle%0d: al/we/ol/done=%b%b%b%b, required 000%b",
                         c, acc_load, mem_we, out_load, instr_done, (c == 5 || c == 10));
            end
        end
        tests++;
        if (pc !== 4'h2 || mem_oe_n !== 1'b1) begin
            fails++;
            $display("FAIL undef_end: pc=%h oe_n=%b, required pc=2 oe_n=1", pc, mem_oe_n);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        run   = 1'b0;
        step  = 1'b0;
        fill_nop();
        test_reset();
        test_free_run();
        test_single_step();
        test_sta();
        test_jmp_wrap();
        test_reset_mid_sta();
        test_undefined_opcode();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
# control_sequencer

Fetch/decode/execute controller for the 8-bit processor. It sequences the 16-entry program/data memory, the instruction register, the program counter and the accumulator/ALU/output strobes. It sits between the memory and the datapath: it drives the memory address, the active-low output enable, the write strobe and the opcode, and it generates one-cycle control pulses for the accumulator and output register. It supports free-run and single-step modes and halts on HLT.

## Interface
Parameters:
- None. Widths are fixed: 4-bit address, 8-bit data, 4-bit opcode.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: level; 1 = fetch instructions back to back.
- `step` in 1: one-cycle pulse; when `run`=0 in IDLE, execute exactly one instruction.
- `mem_rdata` in 8: memory read data; valid in the cycle `mem_oe_n`=0.
- `mem_addr` out 4: memory address.
- `mem_oe_n` out 1: memory output enable, active low.
- `mem_we` out 1: memory write strobe; the accumulator is the write data.
- `op_code` out 4: IR[7:4], fed to memory and ALU.
- `pc` out 4: program counter.
- `acc_load` out 1: load the accumulator from the ALU/memory path.
- `alu_sub` out 1: 1 = subtract, 0 = add/pass.
- `out_load` out 1: load the output register from the accumulator.
- `instr_done` out 1: one-cycle pulse on the last cycle of each completed instruction.
- `halted` out 1: sticky; set by HLT.

## Operation
- Instruction word: [7:4] opcode, [3:0] operand address.
- Opcodes:
  - 0x0 LDA: acc = mem[a].
  - 0x4 ADD: acc = acc + mem[a].
  - 0xC SUB: acc = acc − mem[a].
  - 0x8 STA: mem[a] = acc.
  - 0x6 JMP: pc = a.
  - 0xE OUT.
  - 0xF HLT.
  - All others are NOP.
- States: IDLE, F0, F1, DEC, E0, E1, HALT.
- IDLE: go to F0 if `run`=1 or `step`=1. `run` has priority; `step` is ignored outside IDLE.
- F0: `mem_addr`=pc, `mem_oe_n`=0.
- F1: `mem_addr`=pc, `mem_oe_n`=0; IR <= `mem_rdata`; pc <= pc+1, modulo 16 (15 wraps to 0).
- DEC: no strobes. HLT goes to HALT; every other opcode goes to E0.
- E0:
  - LDA/ADD/SUB: `mem_addr`=IR[3:0], `mem_oe_n`=0.
  - STA: `mem_addr`=IR[3:0], `mem_we`=1, `mem_oe_n`=1.
  - JMP: pc <= IR[3:0].
- E1:
  - LDA/ADD/SUB: `mem_addr`=IR[3:0], `mem_oe_n`=0, `acc_load`=1. `alu_sub`=1 only for SUB.
  - OUT: `out_load`=1.
  - All opcodes: `instr_done`=1.
  - Next state: F0 if `run`=1, else IDLE.
- HALT: absorbing state; `halted`=1; all strobes inactive. Only `rst` exits.
- Clearing `run` mid-instruction finishes the current instruction, then the block goes to IDLE.
- Outputs are decoded only from registered state, IR and pc. There is no combinational path from inputs to outputs.
- At most one of `acc_load`, `mem_we`, `out_load` is 1 in any cycle.
- `mem_oe_n`=0 and `mem_we`=1 never occur in the same cycle.

## Timing
- Reset values:
  - State: IDLE.
  - `pc`=0, IR=0x00.
  - `mem_addr`=0, `mem_oe_n`=1, `mem_we`=0, `op_code`=0.
  - `acc_load`=0, `alu_sub`=0, `out_load`=0, `instr_done`=0, `halted`=0.
- `rst` takes effect immediately, including mid-instruction. A write in progress is aborted with no further strobe.
- Latency:
  - The edge that samples `run`/`step`=1 in IDLE enters F0.
  - Every non-HLT instruction takes 5 cycles (F0..E1).
  - HLT takes 3 cycles (F0, F1, DEC); `halted` rises the cycle after DEC.
- Free-run throughput: one instruction per 5 cycles; E1 goes directly to F0 with no bubble.
- `mem_rdata` is sampled at the end of F1 (into IR). For LDA/ADD/SUB, the datapath samples it at the end of E1, in the same cycle as `acc_load`.
- JMP takes effect at the next F0.
- JMP to 15 followed by a fetch wraps pc to 0.

## Test plan
1. Free run:
   - Stimulus: memory {0:08, 1:C9, 2:EE, 3:FF, 8:01, 9:08}; `rst` then `run`=1.
   - Required: `acc_load` pulses in cycles 5 and 10, with `alu_sub`=1 only in cycle 10 (cycles counted from 1 = first F0). `out_load` pulses in cycle 15. `halted`=1 from cycle 19. With the datapath model, output = 0xF9.
2. Single step:
   - Stimulus: `run`=0, one `step` pulse.
   - Required: exactly 5 active cycles, one `instr_done` pulse, `pc` 0 -> 1, then IDLE. Further `step` pulses asserted during the instruction are ignored.
3. STA:
   - Stimulus: instruction 0x8A.
   - Required: `mem_we`=1 for exactly one cycle (E0) with `mem_addr`=0xA and `mem_oe_n`=1. No `acc_load`.
4. JMP/wrap:
   - Stimulus: 0:6F, 15:30 (NOP).
   - Required: `pc`=15 after the JMP; after fetching address 15, `pc`=0; the next fetch uses `mem_addr`=0.
5. Reset mid-STA:
   - Stimulus: assert `rst` during E0.
   - Required: `mem_we` falls without waiting for a clock edge; all outputs return to reset values; `pc`=0.
6. Undefined opcode:
   - Stimulus: 0x2x, 0xAx.
   - Required: 5 cycles, `instr_done` only, no `acc_load`/`mem_we`/`out_load`, `pc`+1.
